sched_ph: RTL



---
 rtl/sched_ph_pkg.sv | 24 ++
 rtl/sched_ph_next.sv | 24 ++
 rtl/sched_ph.sv | 115 +++++++++++
 3 files changed

// File: rtl/sched_ph_pkg.sv
// Shared constants, action encoding and width helper for the phase scheduler.
package sched_ph_pkg;

  localparam int PH_F  = 0;
  localparam int PH_E  = 1;
  localparam int PH_M  = 2;
  localparam int PH_WB = 3;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  typedef enum logic [1:0] {
    ACT_FREEZE,
    ACT_WAIT,
    ACT_PARK,
    ACT_ADV
  } sched_act_e;

  // Phase index width; at least one bit even for two phases.
  function automatic int ph_width(input int nph);
    return (nph <= 2) ? 1 : $clog2(nph);
  endfunction

endpackage

// File: rtl/sched_ph_next.sv
// Next-phase search: the lowest unskipped index above p, or a wrap to phase 0.
module sched_ph_next #(
  parameter int NPH = 4,
  parameter int PW  = 2
) (
  input  logic [PW-1:0]  p_i,
  input  logic [NPH-1:0] skip_i,
  output logic [PW-1:0]  nxt_o,
  output logic           wrap_o
);

  // Scanning downwards lets the lowest qualifying index win.
  always_comb begin
    nxt_o  = '0;
    wrap_o = 1'b1;
    for (int q = NPH - 1; q >= 1; q--) begin
      if (PW'(q) > p_i && !skip_i[q]) begin
        nxt_o  = PW'(q);
        wrap_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sched_ph.sv
// Parametrised CPU phase scheduler: one-hot phases with skip, wait states,
// hold, single-step and a retired-instruction counter. Flops use the falling edge.
//
// action     | meaning
// ACT_FREEZE | hold or en low: nothing changes
// ACT_WAIT   | wait states remain: count down, stay in phase
// ACT_PARK   | single-step parked in fetch, no step this edge
// ACT_ADV    | move to the next unskipped phase (wrap retires)
module sched_ph
  import sched_ph_pkg::*;
#(
  parameter  int NPH = 4,
  parameter  int WSW = 4,
  parameter  int ICW = 16,
  localparam int PW  = ph_width(NPH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           hold,
  input  logic           mode,
  input  logic           step,
  input  logic [NPH-1:0] skip,
  input  logic [NPH-1:0] stretch,
  input  logic [WSW-1:0] ws,
  output logic [NPH-1:0] ph,
  output logic [PW-1:0]  clk_stat,
  output logic           first,
  output logic           done,
  output logic [ICW-1:0] icnt
);

  logic [PW-1:0]  p_q, p_d;
  logic [WSW-1:0] wc_q, wc_d;
  logic           first_q, first_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic [PW-1:0]  nxt;
  logic           nxt_wrap;
  sched_act_e     act;

  sched_ph_next #(
    .NPH (NPH),
    .PW  (PW)
  ) u_next (
    .p_i    (p_q),
    .skip_i (skip),
    .nxt_o  (nxt),
    .wrap_o (nxt_wrap)
  );

  // Hold outranks the wait countdown so stalls never eat wait states.
  always_comb begin
    act = ACT_ADV;
    if (hold || !en) begin
      act = ACT_FREEZE;
    end else if (wc_q != '0) begin
      act = ACT_WAIT;
    end else if (p_q == PW'(PH_F) && mode == MODE_STEP && !step) begin
      act = ACT_PARK;
    end
  end

  always_comb begin
    p_d     = p_q;
    wc_d    = wc_q;
    first_d = first_q;
    icnt_d  = icnt_q;
    done    = 1'b0;
    unique case (act)
      ACT_FREEZE: ;
      ACT_WAIT: begin
        wc_d    = wc_q - 1'b1;
        first_d = 1'b0;
      end
      ACT_PARK: begin
        first_d = 1'b0;
      end
      ACT_ADV: begin
        p_d     = nxt;
        wc_d    = stretch[nxt] ? ws : '0;
        first_d = 1'b1;
        // A reset edge abandons the instruction, so it never retires.
        if (nxt_wrap && reset) begin
          done   = 1'b1;
          icnt_d = icnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      p_q     <= '0;
      wc_q    <= '0;
      first_q <= 1'b1;
      icnt_q  <= '0;
    end else begin
      p_q     <= p_d;
      wc_q    <= wc_d;
      first_q <= first_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    ph      = '0;
    ph[p_q] = 1'b1;
  end

  assign clk_stat = p_q;
  assign first    = first_q;
  assign icnt     = icnt_q;

endmodule
